// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared byte width and Tx framing state encoding for the system-control path.
package sys_ctrl_pkg;
    localparam int WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        SEND_RD     = 2'b01,
        SEND_ALU_LO = 2'b10,
        SEND_ALU_HI = 2'b11
    } tx_state_t;
endpackage

// File: rtl/sys_tx_control_if.sv
// sys_tx_control_if: result inputs, Tx FIFO write side and status of the Tx framing stage.
interface sys_tx_control_if
    import sys_ctrl_pkg::*;
#(
    parameter int width = WIDTH
);
    logic [width-1:0]   RdData;
    logic               RdValid;
    logic [2*width-1:0] ALU_OUT;
    logic               ALU_Valid;
    logic               FIFO_Full;
    logic [width-1:0]   FIFO_WrData;
    logic               FIFO_WrINC;
    logic               Busy;
    logic               Drop;
    modport master (
        output RdData, RdValid, ALU_OUT, ALU_Valid, FIFO_Full,
        input  FIFO_WrData, FIFO_WrINC, Busy, Drop
    );
    modport slave (
        input  RdData, RdValid, ALU_OUT, ALU_Valid, FIFO_Full,
        output FIFO_WrData, FIFO_WrINC, Busy, Drop
    );
endinterface

// File: rtl/sys_tx_slot.sv
// sys_tx_slot: one pending result (data + full bit); a capture on the clearing edge refills the slot.
module sys_tx_slot #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             clr,
    input  logic [width-1:0] din,
    output logic [width-1:0] data,
    output logic             full,
    output logic             full_nxt,
    output logic             drop
);
    logic take;
    assign take     = valid & (~full | clr);
    assign full_nxt = take | (full & ~clr);
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            full <= 1'b0;
            drop <= 1'b0;
        end else begin
            full <= full_nxt;
            drop <= valid & full & ~clr;
            if (take) data <= din;
        end
    end
endmodule

// File: rtl/sys_tx_control.sv
// sys_tx_control: frames read results (1 byte) and ALU results (2 bytes, low first) into the Tx FIFO.
module sys_tx_control
    import sys_ctrl_pkg::*;
#(
    parameter int width = WIDTH
) (
    input  logic             CLK,
    input  logic             Reset,
    sys_tx_control_if.slave  bus
);
    tx_state_t          state, state_nxt;
    logic               wr, rd_clr, alu_clr, busy;
    logic               rd_full, rd_full_nxt, rd_drop;
    logic               alu_full, alu_full_nxt, alu_drop;
    logic [width-1:0]   rd_data;
    logic [2*width-1:0] alu_data;
    // The strobe is the only combinational path, so a full FIFO is never written.
    assign wr      = (state != IDLE) & ~bus.FIFO_Full;
    assign rd_clr  = wr & (state == SEND_RD);
    assign alu_clr = wr & (state == SEND_ALU_HI);
    sys_tx_slot #(.width(width)) u_rd_slot (
        .clk(CLK), .rst(Reset), .valid(bus.RdValid), .clr(rd_clr), .din(bus.RdData),
        .data(rd_data), .full(rd_full), .full_nxt(rd_full_nxt), .drop(rd_drop)
    );
    sys_tx_slot #(.width(2*width)) u_alu_slot (
        .clk(CLK), .rst(Reset), .valid(bus.ALU_Valid), .clr(alu_clr), .din(bus.ALU_OUT),
        .data(alu_data), .full(alu_full), .full_nxt(alu_full_nxt), .drop(alu_drop)
    );
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        state_nxt = rd_full ? SEND_RD : alu_full ? SEND_ALU_LO : IDLE;
            SEND_RD:     if (wr) state_nxt = alu_full ? SEND_ALU_LO : IDLE;
            SEND_ALU_LO: if (wr) state_nxt = SEND_ALU_HI;
            SEND_ALU_HI: if (wr) state_nxt = rd_full ? SEND_RD : IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE) | rd_full_nxt | alu_full_nxt;
        end
    end
    assign bus.FIFO_WrINC  = wr;
    assign bus.FIFO_WrData = state == SEND_RD     ? rd_data :
                             state == SEND_ALU_LO ? alu_data[width-1:0] :
                             state == SEND_ALU_HI ? alu_data[2*width-1:width] : '0;
    assign bus.Busy = busy;
    assign bus.Drop = rd_drop | alu_drop;
endmodule
